// File: rtl/ghost4_mover_pkg.sv
// Shared Pac-Man game definitions used by every ghost mover.
// Holds the direction encoding, mover FSM states and grid geometry.
package pacman_defs;

  localparam int                  COORD_W  = 5;
  localparam logic [COORD_W-1:0]  GRID_MAX = 5'd20;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ORDER = 3'd2,
    ST_CHECK = 3'd3,
    ST_QUERY = 3'd4,
    ST_NEXT  = 3'd5,
    ST_WRITE = 3'd6,
    ST_DONE  = 3'd7
  } mover_state_t;

  // Opposite direction: up<->down, left<->right.
  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'd2);
  endfunction

endpackage

// File: rtl/ghost4_mover_dir_order.sv
// Chase-heuristic candidate ordering shared by the ghost movers.
// Ranks all four directions toward Pac-Man and demotes the U-turn to last.
module ghost_dir_order
  import pacman_defs::*;
(
  input  logic signed [5:0] dx,
  input  logic signed [5:0] dy,
  input  logic [1:0]        dir_last,
  output logic [3:0][1:0]   cand
);

  logic signed [5:0] adx;
  logic signed [5:0] ady;
  dir_t              prim;
  dir_t              sec;
  dir_t              demote;
  dir_t              base [4];
  int                slot;

  always_comb begin
    adx = (dx < 0) ? -dx : dx;
    ady = (dy < 0) ? -dy : dy;

    if (adx >= ady) begin
      prim = (dx < 0) ? DIR_LEFT : DIR_RIGHT;
      sec  = (dy > 0) ? DIR_DOWN : DIR_UP;
    end else begin
      prim = (dy < 0) ? DIR_UP : DIR_DOWN;
      sec  = (dx > 0) ? DIR_RIGHT : DIR_LEFT;
    end

    base[0] = prim;
    base[1] = sec;
    base[2] = reverse(sec);
    base[3] = reverse(prim);
    demote  = reverse(dir_t'(dir_last));

    // The four entries are a permutation, so exactly one matches the U-turn.
    cand = '0;
    slot = 0;
    for (int j = 0; j < 4; j++) begin
      if (base[j] != demote) begin
        cand[slot[1:0]] = base[j];
        slot = slot + 1;
      end
    end
    cand[3] = demote;
  end

endmodule

// File: rtl/ghost4_mover.sv
// Ghost4 movement controller: on each tick, picks the best open neighbour
// via the wall-memory handshake and writes it to the coordinate register.
module ghost4_mover #(
  parameter int         TICK_CYCLES = 12_500_000,
  parameter logic [4:0] GRID_MAX    = pacman_defs::GRID_MAX,
  parameter logic [4:0] START_X     = 5'd2,
  parameter logic [4:0] START_Y     = 5'd2
) (
  input  logic       clock_50,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [4:0] ghost_x_in,
  input  logic [4:0] ghost_y_in,
  input  logic [4:0] pacman_x,
  input  logic [4:0] pacman_y,
  output logic       wall_req,
  output logic [4:0] wall_x,
  output logic [4:0] wall_y,
  input  logic       wall_ack,
  input  logic       wall_is_wall,
  output logic [4:0] x_out,
  output logic [4:0] y_out,
  output logic       en,
  output logic       readwrite,
  output logic [1:0] dir_out,
  output logic       move_done
);
  import pacman_defs::*;

  localparam int               CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);

  mover_state_t      state;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;
  logic [1:0]        k;

  logic [COORD_W-1:0] gx;
  logic [COORD_W-1:0] gy;
  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  logic [3:0][1:0]    cand_q;
  logic [3:0][1:0]    ord;

  logic signed [5:0] dx;
  logic signed [5:0] dy;
  logic signed [5:0] nx;
  logic signed [5:0] ny;
  logic signed [5:0] grid_lim;
  logic              nb_ok;
  dir_t              cur_dir;

  // Free-running move tick; a terminal count outside IDLE is simply lost.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (enable) begin
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (tick_cnt == TICK_LAST);

  // Coordinate snapshot and candidate list; pure datapath, no reset needed.
  always_ff @(posedge clock_50) begin
    if (state == ST_LOAD) begin
      gx <= ghost_x_in;
      gy <= ghost_y_in;
      px <= pacman_x;
      py <= pacman_y;
    end
    if (state == ST_ORDER) begin
      cand_q <= ord;
    end
  end

  assign dx = $signed({1'b0, px}) - $signed({1'b0, gx});
  assign dy = $signed({1'b0, py}) - $signed({1'b0, gy});

  ghost_dir_order u_dir_order (
    .dx       (dx),
    .dy       (dy),
    .dir_last (dir_out),
    .cand     (ord)
  );

  assign cur_dir  = dir_t'(cand_q[k]);
  assign grid_lim = $signed({1'b0, GRID_MAX});

  always_comb begin
    nx = $signed({1'b0, gx});
    ny = $signed({1'b0, gy});
    case (cur_dir)
      DIR_UP:    ny = ny - 6'sd1;
      DIR_RIGHT: nx = nx + 6'sd1;
      DIR_DOWN:  ny = ny + 6'sd1;
      default:   nx = nx - 6'sd1;
    endcase
    nb_ok = (nx >= 0) && (ny >= 0) && (nx <= grid_lim) && (ny <= grid_lim);
  end

  // Attempt sequencer; the write is issued from QUERY so en lands in WRITE.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      k         <= 2'd0;
      wall_req  <= 1'b0;
      wall_x    <= '0;
      wall_y    <= '0;
      x_out     <= START_X;
      y_out     <= START_Y;
      en        <= 1'b0;
      readwrite <= 1'b1;
      dir_out   <= 2'd0;
      move_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tick) state <= ST_LOAD;
        end
        ST_LOAD: begin
          state <= ST_ORDER;
        end
        ST_ORDER: begin
          k <= 2'd0;
          if (dx == 6'sd0 && dy == 6'sd0) begin
            move_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (nb_ok) begin
            wall_req <= 1'b1;
            wall_x   <= nx[4:0];
            wall_y   <= ny[4:0];
            state    <= ST_QUERY;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_QUERY: begin
          if (wall_req && wall_ack) begin
            wall_req <= 1'b0;
            if (!wall_is_wall) begin
              en        <= 1'b1;
              readwrite <= 1'b0;
              x_out     <= wall_x;
              y_out     <= wall_y;
              dir_out   <= cand_q[k];
              state     <= ST_WRITE;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        ST_NEXT: begin
          if (k == 2'd3) begin
            move_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            k     <= k + 2'd1;
            state <= ST_CHECK;
          end
        end
        ST_WRITE: begin
          en        <= 1'b0;
          readwrite <= 1'b1;
          move_done <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          move_done <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ghost4_mover.sv
// Directed bench for ghost4_mover: vector table of move attempts plus
// hand-written reset-abort, stall and stray-acknowledge sequences.
module tb_ghost4_mover;

  localparam int TICK = 16;

  logic       clock_50;
  logic       reset_n;
  logic       enable;
  logic [4:0] ghost_x_in, ghost_y_in, pacman_x, pacman_y;
  logic       wall_req;
  logic [4:0] wall_x, wall_y;
  logic       wall_ack, wall_is_wall;
  logic [4:0] x_out, y_out;
  logic       en, readwrite;
  logic [1:0] dir_out;
  logic       move_done;

  ghost4_mover #(.TICK_CYCLES(TICK)) dut (
    .clock_50     (clock_50),
    .reset_n      (reset_n),
    .enable       (enable),
    .ghost_x_in   (ghost_x_in),
    .ghost_y_in   (ghost_y_in),
    .pacman_x     (pacman_x),
    .pacman_y     (pacman_y),
    .wall_req     (wall_req),
    .wall_x       (wall_x),
    .wall_y       (wall_y),
    .wall_ack     (wall_ack),
    .wall_is_wall (wall_is_wall),
    .x_out        (x_out),
    .y_out        (y_out),
    .en           (en),
    .readwrite    (readwrite),
    .dir_out      (dir_out),
    .move_done    (move_done)
  );

  initial clock_50 = 1'b0;
  always #5 clock_50 = ~clock_50;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Wall memory model: fixed list of blocked cells, configurable ack delay.
  logic [9:0] walls [3];
  int         n_walls      = 0;
  int         stall_cycles = 0;
  int         wait_cnt     = 0;
  logic       resp_ack     = 1'b0;
  logic       resp_wall    = 1'b0;
  logic       spur_ack     = 1'b0;
  int         q_n          = 0;
  logic [4:0] q_x [8];
  logic [4:0] q_y [8];
  int         en_count     = 0;

  assign wall_ack     = resp_ack | spur_ack;
  assign wall_is_wall = resp_wall;

  function automatic logic is_wall(input logic [4:0] x, input logic [4:0] y);
    for (int i = 0; i < n_walls; i++)
      if (walls[i] == {x, y}) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [9:0] c(input int x, input int y);
    return {x[4:0], y[4:0]};
  endfunction

  always @(negedge clock_50) begin
    if (wall_req && !resp_ack) begin
      if (wait_cnt >= stall_cycles) begin
        resp_ack  = 1'b1;
        resp_wall = is_wall(wall_x, wall_y);
        if (q_n < 8) begin
          q_x[q_n] = wall_x;
          q_y[q_n] = wall_y;
        end
        q_n++;
      end else begin
        wait_cnt++;
      end
    end else begin
      resp_ack  = 1'b0;
      resp_wall = 1'b0;
      wait_cnt  = 0;
    end
  end

  always @(negedge clock_50) if (en === 1'b1) en_count++;

  typedef struct {
    logic             do_reset;
    logic [4:0]       gx, gy, px, py;
    int               nw;
    logic [2:0][9:0]  w;
    logic             wr;
    logic [4:0]       ex, ey;
    logic [1:0]       edir;
    int               nq;
    logic [2:0][9:0]  q;
    int               done_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic apply_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clock_50);
    @(negedge clock_50);
    reset_n = 1'b1;
  endtask

  task automatic run_vec(input int vi);
    vec_t v;
    int   n, en_start, en_at;
    logic got_done;
    v = vecs[vi];
    if (v.do_reset) apply_reset();
    ghost_x_in = v.gx; ghost_y_in = v.gy;
    pacman_x   = v.px; pacman_y   = v.py;
    n_walls = v.nw;
    for (int i = 0; i < 3; i++) walls[i] = v.w[i];
    for (int i = 0; i < 8; i++) begin q_x[i] = 5'd31; q_y[i] = 5'd31; end
    q_n = 0;
    stall_cycles = 0;
    en_start = en_count;
    en_at = -1;
    got_done = 1'b0;
    n = 0;
    @(negedge clock_50);
    enable = 1'b1;
    while (!got_done && n < 200) begin
      @(posedge clock_50);
      n++;
      @(negedge clock_50);
      if (en === 1'b1) begin
        en_at = n;
        check($sformatf("v%0d_readwrite_in_write", vi), {31'd0, readwrite}, 32'd0);
      end
      if (move_done === 1'b1) got_done = 1'b1;
    end
    enable = 1'b0;
    check($sformatf("v%0d_move_done_seen", vi), {31'd0, got_done}, 32'd1);
    check($sformatf("v%0d_en_pulses", vi), en_count - en_start, {31'd0, v.wr});
    check($sformatf("v%0d_x_out", vi), {27'd0, x_out}, {27'd0, v.ex});
    check($sformatf("v%0d_y_out", vi), {27'd0, y_out}, {27'd0, v.ey});
    check($sformatf("v%0d_dir_out", vi), {30'd0, dir_out}, {30'd0, v.edir});
    check($sformatf("v%0d_query_count", vi), q_n, v.nq);
    for (int i = 0; i < v.nq; i++)
      check($sformatf("v%0d_query%0d_cell", vi, i), {22'd0, q_x[i], q_y[i]}, {22'd0, v.q[i]});
    if (v.wr) check($sformatf("v%0d_en_before_done", vi), en_at, n - 1);
    if (v.done_lat != 0) check($sformatf("v%0d_tick_to_done", vi), n, v.done_lat);
  endtask

  initial begin
    int   n, en_start, req_cycles;
    logic seen, stable;

    #2_000_000;
    $display("FAIL global_timeout actual=%0d required=%0d", checks, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int   n, en_start;
    logic seen, stable, got_done, extra_req;

    reset_n = 1'b0; enable = 1'b0;
    ghost_x_in = 5'd2; ghost_y_in = 5'd2; pacman_x = 5'd2; pacman_y = 5'd2;
    for (int i = 0; i < 3; i++) walls[i] = '0;

    vecs[0] = '{do_reset:1'b1, gx:5'd2, gy:5'd2, px:5'd10, py:5'd3, nw:0, w:'0,
                wr:1'b1, ex:5'd3, ey:5'd2, edir:2'd1, nq:1, q:{c(0,0), c(0,0), c(3,2)}, done_lat:21};
    vecs[1] = '{do_reset:1'b0, gx:5'd2, gy:5'd2, px:5'd10, py:5'd3, nw:2, w:{c(0,0), c(2,3), c(3,2)},
                wr:1'b1, ex:5'd2, ey:5'd1, edir:2'd0, nq:3, q:{c(2,1), c(2,3), c(3,2)}, done_lat:0};
    vecs[2] = '{do_reset:1'b1, gx:5'd0, gy:5'd0, px:5'd0, py:5'd0, nw:0, w:'0,
                wr:1'b0, ex:5'd2, ey:5'd2, edir:2'd0, nq:0, q:'0, done_lat:18};
    vecs[3] = '{do_reset:1'b0, gx:5'd0, gy:5'd5, px:5'd0, py:5'd9, nw:3, w:{c(0,4), c(1,5), c(0,6)},
                wr:1'b0, ex:5'd2, ey:5'd2, edir:2'd0, nq:3, q:{c(0,6), c(0,4), c(1,5)}, done_lat:0};
    vecs[4] = '{do_reset:1'b1, gx:5'd2, gy:5'd2, px:5'd10, py:5'd3, nw:0, w:'0,
                wr:1'b1, ex:5'd3, ey:5'd2, edir:2'd1, nq:1, q:{c(0,0), c(0,0), c(3,2)}, done_lat:21};
    vecs[5] = '{do_reset:1'b0, gx:5'd5, gy:5'd5, px:5'd1, py:5'd5, nw:0, w:'0,
                wr:1'b1, ex:5'd5, ey:5'd4, edir:2'd0, nq:1, q:{c(0,0), c(0,0), c(5,4)}, done_lat:0};
    vecs[6] = '{do_reset:1'b0, gx:5'd20, gy:5'd20, px:5'd20, py:5'd0, nw:2, w:{c(0,0), c(19,20), c(20,19)},
                wr:1'b0, ex:5'd5, ey:5'd4, edir:2'd0, nq:2, q:{c(0,0), c(19,20), c(20,19)}, done_lat:0};
    vecs[7] = '{do_reset:1'b0, gx:5'd0, gy:5'd0, px:5'd3, py:5'd0, nw:1, w:{c(0,0), c(0,0), c(1,0)},
                wr:1'b1, ex:5'd0, ey:5'd1, edir:2'd2, nq:2, q:{c(0,0), c(0,1), c(1,0)}, done_lat:0};

    // Reset values while reset_n is held low.
    repeat (2) @(posedge clock_50);
    @(negedge clock_50);
    check("rst_en", {31'd0, en}, 32'd0);
    check("rst_readwrite", {31'd0, readwrite}, 32'd1);
    check("rst_wall_req", {31'd0, wall_req}, 32'd0);
    check("rst_move_done", {31'd0, move_done}, 32'd0);
    check("rst_wall_xy", {22'd0, wall_x, wall_y}, 32'd0);
    check("rst_xy_out", {22'd0, x_out, y_out}, {22'd0, c(2,2)});
    check("rst_dir_out", {30'd0, dir_out}, 32'd0);

    for (int vi = 0; vi < 8; vi++) run_vec(vi);

    // Stray acknowledge while idle must be ignored.
    en_start = en_count;
    seen = 1'b0;
    spur_ack = 1'b1;
    repeat (5) begin
      @(negedge clock_50);
      if (wall_req !== 1'b0) seen = 1'b1;
    end
    spur_ack = 1'b0;
    check("spur_ack_no_req", {31'd0, seen}, 32'd0);
    check("spur_ack_no_en", en_count - en_start, 32'd0);
    check("spur_ack_xy_held", {22'd0, x_out, y_out}, {22'd0, c(0,1)});

    // Reset asserted mid-query aborts the attempt asynchronously.
    ghost_x_in = 5'd2; ghost_y_in = 5'd2; pacman_x = 5'd10; pacman_y = 5'd3;
    n_walls = 0; stall_cycles = 1000; en_start = en_count;
    seen = 1'b0; n = 0;
    @(negedge clock_50);
    enable = 1'b1;
    while (!seen && n < 100) begin
      @(negedge clock_50);
      n++;
      if (wall_req === 1'b1) seen = 1'b1;
    end
    check("abort_req_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clock_50);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_req_async_drop", {31'd0, wall_req}, 32'd0);
    check("abort_en", {31'd0, en}, 32'd0);
    check("abort_readwrite", {31'd0, readwrite}, 32'd1);
    check("abort_xy_out", {22'd0, x_out, y_out}, {22'd0, c(2,2)});
    check("abort_dir_out", {30'd0, dir_out}, 32'd0);
    enable = 1'b0;
    repeat (2) @(posedge clock_50);
    @(negedge clock_50);
    reset_n = 1'b1;
    check("abort_no_write", en_count - en_start, 32'd0);

    // Long wall stall spanning several terminal counts: exactly one write.
    apply_reset();
    stall_cycles = 40; q_n = 0; en_start = en_count;
    got_done = 1'b0; stable = 1'b1; n = 0;
    @(negedge clock_50);
    enable = 1'b1;
    while (!got_done && n < 300) begin
      @(negedge clock_50);
      n++;
      if (wall_req === 1'b1 && {wall_x, wall_y} !== c(3,2)) stable = 1'b0;
      if (move_done === 1'b1) got_done = 1'b1;
    end
    enable = 1'b0;
    check("stall_done_seen", {31'd0, got_done}, 32'd1);
    check("stall_wall_xy_stable", {31'd0, stable}, 32'd1);
    extra_req = 1'b0;
    repeat (40) begin
      @(negedge clock_50);
      if (wall_req !== 1'b0) extra_req = 1'b1;
    end
    stall_cycles = 0;
    check("stall_no_extra_attempt", {31'd0, extra_req}, 32'd0);
    check("stall_single_write", en_count - en_start, 32'd1);
    check("stall_xy_out", {22'd0, x_out, y_out}, {22'd0, c(3,2)});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghost4_mover.md
# ghost4_mover

Movement controller for Ghost4, directly upstream of the Ghost4 coordinate register. On every move tick it reads Ghost4's current cell and Pac-Man's cell, ranks the four directions by a chase heuristic, queries the maze wall memory for each candidate in turn, and writes the first open neighbour back into the coordinate register. A write is a one-cycle pulse of `en=1` with `readwrite=0`. If every neighbour is blocked, nothing is written.

## Interface
- `TICK_CYCLES`, default 12_500_000: `clock_50` cycles between move attempts (4 moves/s).
- `GRID_MAX`, default 5'd20: largest legal x/y coordinate; the legal range is 0..GRID_MAX.
- `START_X` / `START_Y`, default 5'd2 / 5'd2: reset value of `x_out` / `y_out`.

Ports:
- `clock_50`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `enable`  in  1: 0 freezes the tick counter; an attempt already in progress completes.
- `ghost_x_in`, `ghost_y_in`  in  5: current Ghost4 coordinates from the register outputs.
- `pacman_x`, `pacman_y`  in  5: current Pac-Man coordinates.
- `wall_req`  out  1: wall lookup request; held high until acknowledged.
- `wall_x`, `wall_y`  out  5: cell being looked up; stable while `wall_req` is high.
- `wall_ack`  in  1: lookup result valid; sampled only while `wall_req=1`.
- `wall_is_wall`  in  1: 1 means the cell is blocked; valid with `wall_ack`.
- `x_out`, `y_out`  out  5: new coordinates, driven to the register's `x_in` / `y_in`.
- `en`  out  1: register enable.
- `readwrite`  out  1: 0 means write. Idles at 1.
- `dir_out`  out  2: last direction moved.
- `move_done`  out  1: one-cycle pulse at the end of every attempt.

## Operation
- Direction encoding: 0 = up (y-1), 1 = right (x+1), 2 = down (y+1), 3 = left (x-1). reverse(d) = d XOR 2.
- Tick counter:
  - Counts 0..TICK_CYCLES-1 while `enable=1`, then wraps.
  - The terminal count starts an attempt only in IDLE; a terminal count reached in any other state is dropped.
- States:
  - IDLE: wait for a tick.
  - LOAD: latch ghost and Pac-Man coordinates.
  - ORDER: build the candidate list; set index k=0.
  - CHECK: compute the neighbour cell of candidate k.
    - If that cell is outside 0..GRID_MAX, treat it as a wall (no query) and go to NEXT.
    - Otherwise go to QUERY.
  - QUERY: `wall_req=1` until `wall_ack`.
    - `wall_is_wall=0` goes to WRITE.
    - `wall_is_wall=1` goes to NEXT.
  - NEXT: k++. At k=4 go to DONE with no write; otherwise go to CHECK.
  - WRITE: one-cycle write pulse; `dir_out` <= candidate.
  - DONE: `move_done` pulse, then IDLE.
- Candidate ordering uses signed 6-bit deltas dx = pacman_x - ghost_x and dy = pacman_y - ghost_y.
  - If |dx| >= |dy|, the primary axis is horizontal; otherwise it is vertical.
  - Primary: the direction toward Pac-Man on the primary axis.
  - Secondary: the direction toward Pac-Man on the minor axis. If the minor delta is 0, use up (minor axis vertical) or left (minor axis horizontal).
  - Third: reverse(secondary). Fourth: reverse(primary).
  - The candidate equal to reverse(`dir_out`) is moved to the end of the list; the others keep their relative order.
  - If dx = dy = 0 (ghost is on Pac-Man), go straight from ORDER to DONE with no query and no write.
- Reset mid-attempt:
  - Aborts the attempt and drops `wall_req` immediately.
  - No write is issued.
  - All outputs take their reset values.

## Timing
- Reset values:
  - `en`=0, `readwrite`=1, `wall_req`=0, `move_done`=0.
  - `wall_x` / `wall_y`=0, `x_out`=START_X, `y_out`=START_Y, `dir_out`=0.
  - Tick counter=0, state=IDLE.
- All outputs are registered.
- Per-candidate cost: an in-bounds candidate costs 2 cycles plus the wall latency (CHECK, then QUERY held until `wall_ack`); an out-of-bounds candidate costs 2 cycles (CHECK, NEXT).
- Latency from the terminal-count cycle to the `en` pulse is 5 cycles when the first candidate is open with `wall_ack` on the first QUERY cycle.
- `en=1` / `readwrite=0` lasts exactly one cycle.
  - `x_out` / `y_out` are valid in that cycle and held until the next write.
  - The register updates at the end of that cycle, so the new `ghost_x_in` is visible one cycle later.
- `wall_x` / `wall_y` change only when `wall_req=0`. A `wall_ack` with `wall_req=0` is ignored.
- `move_done` is asserted the cycle after WRITE, or after the failed last candidate, or after the dx = dy = 0 hold.

## Structure
- The shared package `pacman_defs` holds:
  - the direction encoding and the `reverse` function;
  - the state encoding;
  - the 5-bit coordinate width and GRID_MAX.
- Sub-module `ghost_dir_order`: a combinational block taking dx, dy and `dir_out`, producing four 2-bit candidates. It is reused by the other ghost movers.
- The tick counter, FSM and wall handshake stay in `ghost4_mover`.

## Test plan
- Open maze, ghost at (2,2), Pac-Man at (10,3), `dir_out`=0, `wall_ack` next cycle with `wall_is_wall=0`: exactly one `en` pulse with `readwrite=0` and `x_out`,`y_out` = (3,2), `dir_out`=1, then `move_done`.
- Same setup, walls at (3,2) and (2,3): queries go to (3,2), then (2,3), then (2,1); write (2,1), `dir_out`=0.
- Ghost at (0,0), Pac-Man at (0,0): no `wall_req`, no `en`, `move_done` 2 cycles after LOAD. Ghost at (0,5), Pac-Man at (0,9), with down (0,6), right (1,5) and up (0,4) all walls: left (-1,5) is skipped without a query, no write, and `move_done` is asserted.
- `dir_out`=1 (right), ghost at (5,5), Pac-Man at (1,5), all cells open: the left candidate is demoted to last, so the write goes to (5,4).
- Assert `reset_n`=0 while `wall_req`=1: `wall_req` drops asynchronously, no `en` is ever pulsed, and the outputs return to (2,2) with `readwrite`=1. Tick terminal counts held during a long `wall_ack` stall are dropped, so exactly one write occurs.
